pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline sequencing controller for the in-order RISC-V core. It drives per-stage stall and flush/bubble controls for the pc, if_id, id_exe, exe_mem and mem_wb pipeline registers. It resolves four hazard sources in a fixed priority: data-memory wait, multicycle execute op, taken jump/branch in exe, and load-use. It also keeps stall/flush performance counters.

## Interface
- RADDR_WIDTH, 5, register address width
- ADDR_WIDTH, 32, instruction address width
- MC_CYCLES, 32, stall cycles per multicycle exe op; legal range 1..255
- CNT_WIDTH, 32, performance counter width
- clk_i  in  1  clock; all state updates on posedge
- rst_i  in  1  reset, synchronous, active-low
- id_rs1_addr_i, id_rs2_addr_i  in  RADDR_WIDTH  source regs of the instruction in id
- id_rs1_re_i, id_rs2_re_i  in  1  source-read enables
- exe_load_i  in  1  instruction in exe is a load
- exe_rd_addr_i  in  RADDR_WIDTH  destination of the instruction in exe
- exe_mc_i  in  1  instruction in exe is multicycle (div/rem)
- exe_jump_i  in  1  taken jump/branch resolved in exe
- exe_jump_addr_i  in  ADDR_WIDTH  redirect target
- mem_wait_i  in  1  data memory not ready
- stall_o  out  5  hold enables: [0] pc, [1] if_id, [2] id_exe, [3] exe_mem, [4] mem_wb
- flush_o  out  3  NOP-insert: [0] if_id, [1] id_exe, [2] exe_mem
- jump_o  out  1  pc redirect
- jump_addr_o  out  ADDR_WIDTH  redirect target
- mc_done_o  out  1  multicycle result valid this cycle
- busy_o  out  1  state is MC_BUSY
- stall_cnt_o  out  CNT_WIDTH  cycles with any stall_o bit set
- flush_cnt_o  out  CNT_WIDTH  cycles with jump_o set

## Operation
- States: IDLE and MC_BUSY. The down-counter cnt is 8 bits.
- Outputs are combinational from state, cnt and inputs. State, cnt and the perf counters are registered.
- While rst_i=0, every output is forced to 0. On the clock edge with rst_i=0: state<=IDLE, cnt<=0, both perf counters<=0. Reset applies from any state, including mid-MC_BUSY.
- Priority, evaluated each cycle. The first matching rule wins.
  1. mem_wait_i=1: stall_o=11111, flush_o=000, jump_o=0, mc_done_o=0. State and cnt are frozen.
  2. MC_BUSY, cnt!=0: stall_o=00111, flush_o=100 (bubble into exe_mem). cnt<=cnt-1.
  3. MC_BUSY, cnt==0: mc_done_o=1, stall_o=00000, flush_o=000. state<=IDLE. exe_mc_i is ignored in this cycle.
  4. IDLE, exe_mc_i=1: stall_o=00111, flush_o=100. cnt<=MC_CYCLES-1, state<=MC_BUSY.
  5. IDLE, exe_jump_i=1: jump_o=1, jump_addr_o=exe_jump_addr_i, flush_o=011, stall_o=00000.
  6. IDLE, load-use: exe_load_i=1, exe_rd_addr_i!=0, and (id_rs1_re_i with rs1==rd, or id_rs2_re_i with rs2==rd). Result: stall_o=00011, flush_o=010 (bubble into id_exe).
  7. Otherwise all outputs are 0.
- jump_addr_o is 0 whenever jump_o=0.
- busy_o equals (state==MC_BUSY).
- stall_cnt_o increments when stall_o!=0. flush_cnt_o increments when jump_o=1. Both wrap modulo 2^CNT_WIDTH.
- A jump and a load-use hazard in the same cycle: the jump wins, because the dependent instruction is flushed.
- A register x0 destination never causes a load-use stall.

## Timing
- Stall, flush and jump outputs respond in the same cycle as the inputs (zero latency).
- A multicycle op stalls for exactly MC_CYCLES cycles: the start cycle plus MC_CYCLES-1 MC_BUSY cycles. mc_done_o follows in cycle MC_CYCLES+1. mem_wait_i cycles extend this one for one.
- A load-use stall lasts 1 cycle per occurrence.
- Jump: 1 cycle of redirect and flush. The pc loads the target on the next edge.
- Perf counters are visible one cycle after the qualifying cycle.

## Test plan
- Reset: hold rst_i=0 for 3 cycles with exe_mc_i=1 and exe_jump_i=1 driven. Required: all outputs 0. After release: state IDLE, counters 0.
- Load-use: exe_load_i=1, exe_rd_addr_i=5, id_rs2_addr_i=5, id_rs2_re_i=1. Required: stall_o=00011, flush_o=010 for 1 cycle, and stall_cnt_o=1 next cycle. Repeat with rd=0: no stall.
- Multicycle, MC_CYCLES=4: pulse exe_mc_i held 5 cycles. Required: stall_o=00111 for 4 cycles, mc_done_o=1 on cycle 5, busy_o high on cycles 2-5, stall_cnt_o=4.
- mem_wait during MC_BUSY: assert mem_wait_i for 2 cycles at cnt=2. Required: stall_o=11111 and cnt frozen, with mc_done_o delayed by exactly 2 cycles.
- Jump vs load-use collision: exe_jump_i=1 with exe_jump_addr_i=0x80000040, while the load-use condition is also true. Required: jump_o=1, jump_addr_o=0x80000040, flush_o=011, stall_o=00000, flush_cnt_o=1.
- Reset mid-MC_BUSY at cnt=10. Required: the next cycle is IDLE with busy_o=0, and a new exe_mc_i restarts a full MC_CYCLES stall.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: per-stage stall/flush generation for the in-order core,
// resolving data-memory wait, multicycle execute, taken jumps and load-use hazards.
module pipe_ctrl #(
    parameter int RADDR_WIDTH = 5,
    parameter int ADDR_WIDTH  = 32,
    parameter int MC_CYCLES   = 32,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [RADDR_WIDTH-1:0] id_rs1_addr_i,
    input  logic [RADDR_WIDTH-1:0] id_rs2_addr_i,
    input  logic                   id_rs1_re_i,
    input  logic                   id_rs2_re_i,
    input  logic                   exe_load_i,
    input  logic [RADDR_WIDTH-1:0] exe_rd_addr_i,
    input  logic                   exe_mc_i,
    input  logic                   exe_jump_i,
    input  logic [ADDR_WIDTH-1:0]  exe_jump_addr_i,
    input  logic                   mem_wait_i,
    output logic [4:0]             stall_o,
    output logic [2:0]             flush_o,
    output logic                   jump_o,
    output logic [ADDR_WIDTH-1:0]  jump_addr_o,
    output logic                   mc_done_o,
    output logic                   busy_o,
    output logic [CNT_WIDTH-1:0]   stall_cnt_o,
    output logic [CNT_WIDTH-1:0]   flush_cnt_o
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MC_BUSY = 1'b1
    } state_t;

    // The start cycle already counts as one stall cycle, hence the minus one.
    localparam logic [7:0] MC_LOAD = 8'(MC_CYCLES - 1);

    state_t               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
    logic                 load_use_s;

    assign load_use_s = exe_load_i && (exe_rd_addr_i != {RADDR_WIDTH{1'b0}}) &&
                        ((id_rs1_re_i && (id_rs1_addr_i == exe_rd_addr_i)) ||
                         (id_rs2_re_i && (id_rs2_addr_i == exe_rd_addr_i)));

    // Hazard priority resolution: outputs and next state/count.
    always_comb begin
        stall_o     = 5'b00000;
        flush_o     = 3'b000;
        jump_o      = 1'b0;
        jump_addr_o = {ADDR_WIDTH{1'b0}};
        mc_done_o   = 1'b0;
        busy_o      = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;
        if (!rst_i) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
        end else begin
            busy_o = (state_q == MC_BUSY);
            if (mem_wait_i) begin
                stall_o = 5'b11111;
            end else if (state_q == MC_BUSY) begin
                if (cnt_q != 8'd0) begin
                    stall_o = 5'b00111;
                    flush_o = 3'b100;
                    cnt_d   = cnt_q - 8'd1;
                end else begin
                    mc_done_o = 1'b1;
                    state_d   = IDLE;
                end
            end else if (exe_mc_i) begin
                stall_o = 5'b00111;
                flush_o = 3'b100;
                cnt_d   = MC_LOAD;
                state_d = MC_BUSY;
            end else if (exe_jump_i) begin
                jump_o      = 1'b1;
                jump_addr_o = exe_jump_addr_i;
                flush_o     = 3'b011;
            end else if (load_use_s) begin
                stall_o = 5'b00011;
                flush_o = 3'b010;
            end else begin
                stall_o = 5'b00000;
            end
        end
    end

    // Performance counter next values; outputs are already zero while in reset.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!rst_i) begin
            stall_cnt_d = {CNT_WIDTH{1'b0}};
            flush_cnt_d = {CNT_WIDTH{1'b0}};
        end else begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(stall_o != 5'b00000);
            flush_cnt_d = flush_cnt_q + CNT_WIDTH'(jump_o);
        end
    end

    // State, down-counter and performance counter registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            stall_cnt_q <= {CNT_WIDTH{1'b0}};
            flush_cnt_q <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Zero-gated in reset so every output reads 0 while rst_i is low.
    assign stall_cnt_o = rst_i ? stall_cnt_q : {CNT_WIDTH{1'b0}};
    assign flush_cnt_o = rst_i ? flush_cnt_q : {CNT_WIDTH{1'b0}};

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl; a second instance with a longer multicycle
// latency covers reset in the middle of a long MC_BUSY period.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst_i;
    logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, exe_rd_addr_i;
    logic        id_rs1_re_i, id_rs2_re_i, exe_load_i, exe_mc_i, exe_jump_i, mem_wait_i;
    logic [31:0] exe_jump_addr_i;

    logic [4:0]  stall_o, b_stall;
    logic [2:0]  flush_o, b_flush;
    logic        jump_o, mc_done_o, busy_o, b_jump, b_done, b_busy;
    logic [31:0] jump_addr_o, stall_cnt_o, flush_cnt_o, b_jaddr, b_scnt, b_fcnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_scnt = 32'd0;
    logic [31:0] exp_fcnt = 32'd0;

    typedef struct {
        logic [4:0]  stall;
        logic [2:0]  flush;
        logic        jump;
        logic [31:0] jaddr;
        logic        done;
        logic        busy;
    } exp_t;
    exp_t sb_q[$];

    pipe_ctrl #(.RADDR_WIDTH(5), .ADDR_WIDTH(32), .MC_CYCLES(4), .CNT_WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .id_rs1_re_i(id_rs1_re_i), .id_rs2_re_i(id_rs2_re_i),
        .exe_load_i(exe_load_i), .exe_rd_addr_i(exe_rd_addr_i),
        .exe_mc_i(exe_mc_i), .exe_jump_i(exe_jump_i), .exe_jump_addr_i(exe_jump_addr_i),
        .mem_wait_i(mem_wait_i),
        .stall_o(stall_o), .flush_o(flush_o), .jump_o(jump_o), .jump_addr_o(jump_addr_o),
        .mc_done_o(mc_done_o), .busy_o(busy_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    pipe_ctrl #(.RADDR_WIDTH(5), .ADDR_WIDTH(32), .MC_CYCLES(12), .CNT_WIDTH(32)) dut_b (
        .clk_i(clk), .rst_i(rst_i),
        .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .id_rs1_re_i(id_rs1_re_i), .id_rs2_re_i(id_rs2_re_i),
        .exe_load_i(exe_load_i), .exe_rd_addr_i(exe_rd_addr_i),
        .exe_mc_i(exe_mc_i), .exe_jump_i(exe_jump_i), .exe_jump_addr_i(exe_jump_addr_i),
        .mem_wait_i(mem_wait_i),
        .stall_o(b_stall), .flush_o(b_flush), .jump_o(b_jump), .jump_addr_o(b_jaddr),
        .mc_done_o(b_done), .busy_o(b_busy),
        .stall_cnt_o(b_scnt), .flush_cnt_o(b_fcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        id_rs1_addr_i = 5'd0; id_rs2_addr_i = 5'd0; exe_rd_addr_i = 5'd0;
        id_rs1_re_i = 1'b0; id_rs2_re_i = 1'b0; exe_load_i = 1'b0;
        exe_mc_i = 1'b0; exe_jump_i = 1'b0; exe_jump_addr_i = 32'd0; mem_wait_i = 1'b0;
    endtask

    // One cycle on the main instance: push expectation, compare at negedge, advance.
    task automatic step(input string tag, input logic [4:0] s, input logic [2:0] f,
                        input logic j, input logic [31:0] a, input logic d, input logic b);
        exp_t e;
        exp_t got;
        e.stall = s; e.flush = f; e.jump = j; e.jaddr = a; e.done = d; e.busy = b;
        sb_q.push_back(e);
        @(negedge clk);
        got = sb_q.pop_front();
        chk({tag, "/stall"}, 64'(stall_o), 64'(got.stall));
        chk({tag, "/flush"}, 64'(flush_o), 64'(got.flush));
        chk({tag, "/jump"}, 64'(jump_o), 64'(got.jump));
        chk({tag, "/jaddr"}, 64'(jump_addr_o), 64'(got.jaddr));
        chk({tag, "/done"}, 64'(mc_done_o), 64'(got.done));
        chk({tag, "/busy"}, 64'(busy_o), 64'(got.busy));
        chk({tag, "/scnt"}, 64'(stall_cnt_o), 64'(exp_scnt));
        chk({tag, "/fcnt"}, 64'(flush_cnt_o), 64'(exp_fcnt));
        if (!rst_i) begin
            exp_scnt = 32'd0;
            exp_fcnt = 32'd0;
        end else begin
            if (got.stall != 5'b00000) exp_scnt = exp_scnt + 32'd1;
            if (got.jump) exp_fcnt = exp_fcnt + 32'd1;
        end
        @(posedge clk); #1;
    endtask

    // One cycle on the long-latency instance.
    task automatic bstep(input string tag, input logic [4:0] s, input logic d, input logic b);
        @(negedge clk);
        chk({tag, "/b_stall"}, 64'(b_stall), 64'(s));
        chk({tag, "/b_done"}, 64'(b_done), 64'(d));
        chk({tag, "/b_busy"}, 64'(b_busy), 64'(b));
        @(posedge clk); #1;
    endtask

    initial begin
        idle_inputs();
        rst_i = 1'b0;
        exe_mc_i = 1'b1; exe_jump_i = 1'b1; exe_jump_addr_i = 32'h1234;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) step("reset", 5'b00000, 3'b000, 1'b0, 32'd0, 1'b0, 1'b0);
        rst_i = 1'b1; idle_inputs();
        step("post_reset", 5'b00000, 3'b000, 1'b0, 32'd0, 1'b0, 1'b0);

        // Load-use hazards
        exe_load_i = 1'b1; exe_rd_addr_i = 5'd5; id_rs2_addr_i = 5'd5; id_rs2_re_i = 1'b1;
        id_rs1_addr_i = 5'd3; id_rs1_re_i = 1'b1;
        step("lu_rs2", 5'b00011, 3'b010, 1'b0, 32'd0, 1'b0, 1'b0);
        idle_inputs();
        step("lu_after", 5'b00000, 3'b000, 1'b0, 32'd0, 1'b0, 1'b0);
        exe_load_i = 1'b1; exe_rd_addr_i = 5'd7; id_rs1_addr_i = 5'd7; id_rs1_re_i = 1'b1;
        step("lu_rs1", 5'b00011, 3'b010, 1'b0, 32'd0, 1'b0, 1'b0);
        id_rs1_re_i = 1'b0;
        step("lu_no_re", 5'b00000, 3'b000, 1'b0, 32'd0, 1'b0, 1'b0);
        exe_rd_addr_i = 5'd0; id_rs2_addr_i = 5'd0; id_rs2_re_i = 1'b1;
        step("lu_x0", 5'b00000, 3'b000, 1'b0, 32'd0, 1'b0, 1'b0);
        idle_inputs();

        // Multicycle op, exe_mc_i held 5 cycles
        exe_mc_i = 1'b1;
        step("mc_start", 5'b00111, 3'b100, 1'b0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("mc_busy", 5'b00111, 3'b100, 1'b0, 32'd0, 1'b0, 1'b1);
        step("mc_done", 5'b00000, 3'b000, 1'b0, 32'd0, 1'b1, 1'b1);
        exe_mc_i = 1'b0;
        step("mc_idle", 5'b00000, 3'b000, 1'b0, 32'd0, 1'b0, 1'b0);

        // mem_wait at cnt=2 during MC_BUSY
        exe_mc_i = 1'b1;
        step("mw_start", 5'b00111, 3'b100, 1'b0, 32'd0, 1'b0, 1'b0);
        exe_mc_i = 1'b0;
        step("mw_cnt3", 5'b00111, 3'b100, 1'b0, 32'd0, 1'b0, 1'b1);
        mem_wait_i = 1'b1;
        step("mw_wait1", 5'b11111, 3'b000, 1'b0, 32'd0, 1'b0, 1'b1);
        step("mw_wait2", 5'b11111, 3'b000, 1'b0, 32'd0, 1'b0, 1'b1);
        mem_wait_i = 1'b0;
        step("mw_cnt2", 5'b00111, 3'b100, 1'b0, 32'd0, 1'b0, 1'b1);
        step("mw_cnt1", 5'b00111, 3'b100, 1'b0, 32'd0, 1'b0, 1'b1);
        step("mw_done", 5'b00000, 3'b000, 1'b0, 32'd0, 1'b1, 1'b1);
        mem_wait_i = 1'b1; exe_jump_i = 1'b1; exe_jump_addr_i = 32'h0000_0100;
        step("mw_over_jump", 5'b11111, 3'b000, 1'b0, 32'd0, 1'b0, 1'b0);
        idle_inputs();

        // Jump wins over a simultaneous load-use hazard
        exe_jump_i = 1'b1; exe_jump_addr_i = 32'h8000_0040;
        exe_load_i = 1'b1; exe_rd_addr_i = 5'd9; id_rs1_addr_i = 5'd9; id_rs1_re_i = 1'b1;
        step("jump_lu", 5'b00000, 3'b011, 1'b1, 32'h8000_0040, 1'b0, 1'b0);
        idle_inputs();
        step("jump_after", 5'b00000, 3'b000, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("flush_cnt_one", 64'(exp_fcnt), 64'd1);

        // Reset mid-MC_BUSY on the MC_CYCLES=12 instance at cnt=10
        rst_i = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b1;
        exe_mc_i = 1'b1;
        bstep("b_start", 5'b00111, 1'b0, 1'b0);
        exe_mc_i = 1'b0;
        bstep("b_cnt11", 5'b00111, 1'b0, 1'b1);
        rst_i = 1'b0;
        bstep("b_rst_cnt10", 5'b00000, 1'b0, 1'b0);
        rst_i = 1'b1;
        bstep("b_after_rst", 5'b00000, 1'b0, 1'b0);
        exe_mc_i = 1'b1;
        bstep("b_restart", 5'b00111, 1'b0, 1'b0);
        exe_mc_i = 1'b0;
        for (int i = 1; i < 12; i++) bstep("b_busy", 5'b00111, 1'b0, 1'b1);
        bstep("b_done", 5'b00000, 1'b1, 1'b1);
        bstep("b_idle", 5'b00000, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
